ksa: RTL and testbench

//  ARC4 key-scheduling controller. Sole master of s_mem after init has filled S[i]=i.
//  For i=0..255: j=(j+S[i]+key[i mod 3]) mod 256, then swap S[i] and S[j].

---
 rtl/ksa.sv | 123 ++++++++++++
 tb/tb_ksa.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ksa.sv
// ARC4 key-scheduling controller: permutes S[] in s_mem using the secret key.
// One iteration = read S[i], read S[j], write S[i], write S[j] (6 cycles).
module ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J} state_t;

  state_t                 state, state_nx;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             i, j, si, sj;
  logic [KW-1:0]          kidx;
  logic [7:0]             j_nx;

  // Key byte k is taken big-endian: byte 0 is the most significant byte.
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] k,
                                          input logic [KW-1:0] idx);
    logic [8*KEY_BYTES-1:0] sh;
    sh = k >> (8 * (KEY_BYTES - 1 - int'(idx)));
    return sh[7:0];
  endfunction

  // Next j; only consumed at the end of WT_I, when rddata holds S[i].
  always_comb begin
    j_nx = j + rddata + key_byte(key_q, kidx);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: fixed six-state loop per iteration, exit after i==255.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = RD_I;
      RD_I:    state_nx = WT_I;
      WT_I:    state_nx = RD_J;
      RD_J:    state_nx = WT_J;
      WT_J:    state_nx = WR_I;
      WR_I:    state_nx = WR_J;
      WR_J:    state_nx = (i == 8'd255) ? IDLE : RD_I;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs: each transition loads the outputs of the
  // state being entered, so addr/wrdata/wren are glitch-free register outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy    <= 1'b1;
      addr   <= '0;
      wrdata <= '0;
      wren   <= 1'b0;
      i      <= '0;
      j      <= '0;
      si     <= '0;
      sj     <= '0;
      kidx   <= '0;
      key_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wren <= 1'b0;
          if (en) begin
            key_q <= key;
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            rdy   <= 1'b0;
            addr  <= '0;
          end
        end
        RD_I: begin
          addr <= i;
          wren <= 1'b0;
        end
        WT_I: begin
          si   <= rddata;
          j    <= j_nx;
          addr <= j_nx;
        end
        WT_J: begin
          sj     <= rddata;
          addr   <= i;
          wrdata <= rddata;
          wren   <= 1'b1;
        end
        WR_I: begin
          addr   <= j;
          wrdata <= si;
          wren   <= 1'b1;
        end
        WR_J: begin
          wren <= 1'b0;
          if (i == 8'd255) begin
            rdy <= 1'b1;
          end else begin
            i    <= i + 8'd1;
            addr <= i + 8'd1;
            kidx <= (kidx == KW'(KEY_BYTES - 1)) ? '0 : kidx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: 256x8 memory with 1-cycle read latency plus a
// behavioural key-schedule model.
module tb_ksa;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  logic [7:0]  mem [256];
  logic [7:0]  ref_s [256];
  logic        do_preload;
  logic [15:0] wq [$];

  int checks = 0;
  int errors = 0;

  ksa dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: registered read, write-first not needed; logs every write.
  always @(posedge clk) begin
    if (do_preload) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else begin
      if (wren) begin
        mem[addr] <= wrdata;
        wq.push_back({addr, wrdata});
      end
      rddata <= mem[addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    @(negedge clk); do_preload = 1'b1;
    @(negedge clk); do_preload = 1'b0;
    for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
  endtask

  task automatic model_run(input logic [23:0] k);
    logic [7:0]  jj, t;
    logic [23:0] sh;
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      sh = k >> (8 * (2 - (n % 3)));
      jj = jj + ref_s[n] + sh[7:0];
      t = ref_s[n]; ref_s[n] = ref_s[jj]; ref_s[jj] = t;
    end
  endtask

  task automatic mem_check(input string tag);
    int bad, first;
    bad = 0; first = -1;
    for (int k = 0; k < 256; k++)
      if (mem[k] !== ref_s[k]) begin bad++; if (first < 0) first = k; end
    check(tag, bad, 0);
    if (bad != 0) $display("  first differing index %0d: mem %0h model %0h",
                           first, mem[first], ref_s[first]);
  endtask

  task automatic start(input logic [23:0] k);
    @(negedge clk); key = k; en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
  endtask

  // mode 0: plain wait; 1: toggle en and scramble key mid-run; 2: reset at cycle 700.
  task automatic wait_done(input int mode, output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk); cyc++; #1;
      if (mode == 1) begin
        if (cyc < 1500) begin en = (cyc % 2 == 1); key = $urandom; end
        else en = 1'b0;
      end
      if (mode == 2 && cyc == 700) begin rst_n = 1'b0; return; end
      if (rdy || cyc >= 2000) return;
    end
  endtask

  int cyc, base;

  initial begin
    rst_n = 1'b1; en = 1'b0; key = '0; do_preload = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    check("reset_rdy", rdy, 1);
    check("reset_wren", wren, 0);
    check("reset_addr", addr, 0);
    check("reset_wrdata", wrdata, 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: all-zero key, first three iterations of writes
    preload();
    base = wq.size();
    start(24'h000000);
    wait_done(0, cyc);
    check("t1_w0", wq[base+0], 16'h0000);
    check("t1_w1", wq[base+1], 16'h0000);
    check("t1_w2", wq[base+2], 16'h0101);
    check("t1_w3", wq[base+3], 16'h0101);
    check("t1_w4", wq[base+4], 16'h0203);
    check("t1_w5", wq[base+5], 16'h0302);
    check("t1_cycles", cyc, 1536);
    model_run(24'h000000);
    mem_check("t1_mem");

    // 2: key 010203, iteration 0 swaps S0/S1, iteration 1 lands on j=3
    preload();
    base = wq.size();
    start(24'h010203);
    wait_done(0, cyc);
    check("t2_w0", wq[base+0], 16'h0001);
    check("t2_w1", wq[base+1], 16'h0100);
    check("t2_w2", wq[base+2], 16'h0103);
    check("t2_w3", wq[base+3], 16'h0300);
    model_run(24'h010203);
    mem_check("t2_mem");

    // 3: full run timing, write count, final permutation
    preload();
    base = wq.size();
    start(24'h00033C);
    wait_done(0, cyc);
    check("t3_cycles", cyc, 1536);
    check("t3_wren_pulses", wq.size() - base, 512);
    model_run(24'h00033C);
    mem_check("t3_mem");

    // 4: en toggling and key changes while busy are ignored
    preload();
    base = wq.size();
    start(24'hA5C31E);
    wait_done(1, cyc);
    check("t4_cycles", cyc, 1536);
    check("t4_wren_pulses", wq.size() - base, 512);
    model_run(24'hA5C31E);
    mem_check("t4_mem");

    // 5: asynchronous abort mid-run, then a clean rerun
    preload();
    start(24'h5AF00F);
    wait_done(2, cyc);
    #1;
    check("t5_abort_rdy", rdy, 1);
    check("t5_abort_wren", wren, 0);
    check("t5_abort_addr", addr, 0);
    @(negedge clk); rst_n = 1'b1;
    preload();
    start(24'h5AF00F);
    wait_done(0, cyc);
    check("t5_cycles", cyc, 1536);
    model_run(24'h5AF00F);
    mem_check("t5_mem");

    // 6: en held across completion restarts on the next edge
    preload();
    @(negedge clk); key = 24'h123456; en = 1'b1;
    @(posedge clk); #1;
    wait_done(0, cyc);
    check("t6_first_cycles", cyc, 1536);
    check("t6_rdy_done", rdy, 1);
    @(posedge clk); #1;
    check("t6_restarted", rdy, 0);
    en = 1'b0;
    wait_done(0, cyc);
    check("t6_second_cycles", cyc, 1536);
    model_run(24'h123456);
    model_run(24'h123456);
    mem_check("t6_mem");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
